// File: rtl/counter_4bit_pkg.sv
// counter_4bit_pkg: shared constants and helpers for the 4-bit up-counter.
// Width is fixed at four bits; the reset and terminal values live here so the
// top level and any cascading logic agree on them.
package counter_4bit_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;
  localparam logic [CNT_W-1:0] CNT_RST = 4'h0;

  // True when the count sits in the terminal state that ends one 16-cycle lap.
  function automatic logic isTerminal(input logic [CNT_W-1:0] count);
    return (count == CNT_MAX);
  endfunction

endpackage : counter_4bit_pkg

// File: rtl/counter_4bit_t_ff.sv
// t_ff: single toggle flip-flop with synchronous active-high reset.
// Each counter bit is one of these; the toggle enable comes from the AND chain
// of the lower bits in the top level.
module t_ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_t,
  output logic o_q
);

  logic r_q;

  // Reset wins; otherwise flip the stored bit whenever the toggle enable is high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule : t_ff

// File: rtl/counter_4bit.sv
// counter_4bit: free-running 4-bit synchronous binary up-counter built from
// four toggle flip-flops, with a ripple-carry output for cascading.
//
// Optional feature macro: COUNTER_4BIT_CE_EN
//   defined   -> adds input ce; ce=0 holds the count, and Rc is qualified by ce
//                so a chain of these behaves like 74161 ENT cascading.
//   undefined -> no ce port; counts on every clock; Rc flags count == 15.
module counter_4bit
  import counter_4bit_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
`ifdef COUNTER_4BIT_CE_EN
  input  logic ce,
`endif
  output logic Qa,
  output logic Qb,
  output logic Qc,
  output logic Qd,
  output logic Rc
);

  logic             w_en;
  logic [CNT_W-1:0] w_toggle;
  logic [CNT_W-1:0] w_q;

`ifdef COUNTER_4BIT_CE_EN
  assign w_en = ce;
`else
  assign w_en = 1'b1;
`endif

  // Bit i toggles when every lower bit is 1, which is exactly a binary +1.
  // Reset is applied inside each flop, so it overrides the enable chain.
  always_comb begin
    w_toggle = '0;
    w_toggle[0] = w_en;
    for (int i = 1; i < CNT_W; i++) begin
      w_toggle[i] = w_toggle[i-1] & w_q[i-1];
    end
  end

  for (genvar g = 0; g < CNT_W; g++) begin : gen_bit
    t_ff u_tff (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_t   (w_toggle[g]),
      .o_q   (w_q[g])
    );
  end

  assign Qa = w_q[0];
  assign Qb = w_q[1];
  assign Qc = w_q[2];
  assign Qd = w_q[3];

  // Ripple carry is a single AND level on registered state; with the enable
  // feature it is also gated by ce so an upstream stage can stall the chain.
  assign Rc = w_en & isTerminal(w_q);

endmodule : counter_4bit

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit: directed self-checking bench for counter_4bit.
// Build with +define+COUNTER_4BIT_CE_EN to also exercise the count-enable steps.
module tb_counter_4bit;

  logic clk;
  logic rst;
  logic ce;
  logic Qa, Qb, Qc, Qd, Rc;

  int testsRun;
  int failCount;
  int togA, togB, togC, togD;
  logic [3:0] prevQ;
  logic [3:0] expQ;

  counter_4bit dut (
    .i_clk (clk),
    .i_rst (rst),
`ifdef COUNTER_4BIT_CE_EN
    .ce    (ce),
`endif
    .Qa    (Qa),
    .Qb    (Qb),
    .Qc    (Qc),
    .Qd    (Qd),
    .Rc    (Rc)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges; inputs are changed and outputs sampled on falling edges.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Compare the count and ripple carry against hand-computed values.
  task automatic checkOutput(input string tag, input logic [3:0] wantQ, input logic wantRc);
    testsRun++;
    assert ({Qd, Qc, Qb, Qa} === wantQ && Rc === wantRc)
    else begin
      failCount++;
      $error("[TB] FAIL %s: got Q=%0h Rc=%0b, expected Q=%0h Rc=%0b",
             tag, {Qd, Qc, Qb, Qa}, Rc, wantQ, wantRc);
    end
  endtask

  // Compare a toggle tally against the expected divide ratio.
  task automatic checkCount(input string tag, input int got, input int want);
    testsRun++;
    assert (got === want)
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %0d toggles, expected %0d", tag, got, want);
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst = 1'b1;
    ce  = 1'b1;
    @(negedge clk);

    // Reset held for two edges.
    applyStimulus(2);
    checkOutput("reset_hold", 4'h0, 1'b0);

    // Release reset and walk two full laps, tallying bit toggles.
    rst = 1'b0;
    togA = 0; togB = 0; togC = 0; togD = 0;
    prevQ = 4'h0;
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1);
      expQ = 4'(k % 16);
      checkOutput($sformatf("seq_%0d", k), expQ, (k % 16) == 15);
      if (Qa !== prevQ[0]) togA++;
      if (Qb !== prevQ[1]) togB++;
      if (Qc !== prevQ[2]) togC++;
      if (Qd !== prevQ[3]) togD++;
      prevQ = {Qd, Qc, Qb, Qa};
    end
    checkCount("div2_Qa",  togA, 32);
    checkCount("div4_Qb",  togB, 16);
    checkCount("div8_Qc",  togC, 8);
    checkCount("div16_Qd", togD, 4);

    // Reset mid-count at 9.
    applyStimulus(9);
    checkOutput("run_to_9", 4'h9, 1'b0);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rst_at_9", 4'h0, 1'b0);
    rst = 1'b0;

    // Reset at the terminal count drops Rc on the same edge.
    applyStimulus(15);
    checkOutput("run_to_15", 4'hF, 1'b1);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rst_at_15", 4'h0, 1'b0);
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("resume_after_rst", 4'h1, 1'b0);

`ifdef COUNTER_4BIT_CE_EN
    // Hold at 5 with ce low.
    applyStimulus(4);
    checkOutput("ce_run_to_5", 4'h5, 1'b0);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("ce_hold_%0d", k), 4'h5, 1'b0);
    end

    // Rc is qualified by ce at the terminal count.
    ce = 1'b1;
    applyStimulus(10);
    checkOutput("ce_run_to_15", 4'hF, 1'b1);
    ce = 1'b0;
    #1;
    checkOutput("ce_low_rc_gated", 4'hF, 1'b0);
    applyStimulus(1);
    checkOutput("ce_low_hold_15", 4'hF, 1'b0);
    ce = 1'b1;
    #1;
    checkOutput("ce_high_rc", 4'hF, 1'b1);
    applyStimulus(1);
    checkOutput("ce_wrap", 4'h0, 1'b0);

    // Reset overrides a low ce.
    applyStimulus(7);
    checkOutput("ce_run_to_7", 4'h7, 1'b0);
    rst = 1'b1;
    ce  = 1'b0;
    applyStimulus(1);
    checkOutput("rst_over_ce", 4'h0, 1'b0);
    rst = 1'b0;
    ce  = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule : tb_counter_4bit
